// File: rtl/i2s_rx.sv
// Standard-I2S slave receiver: oversamples BCLK/LRCK/SDATA in the clk domain and
// emits one packed {left,right} word per frame with a single-cycle valid strobe.
module i2s_rx #(
    parameter int CH_WIDTH    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  bclk,
    input  logic                  lrck,
    input  logic                  sdata,
    output logic [2*CH_WIDTH-1:0] audio_out,
    output logic                  valid_out,
    output logic                  frame_err
);

    localparam int DATA_WIDTH = 2 * CH_WIDTH;
    localparam int CW = $clog2(CH_WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(CH_WIDTH);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, sdata_sync;
    logic                   bclk_d;
    logic                   lr_prev;
    logic [CH_WIDTH-1:0]    shreg, shreg_nxt, left_hold;
    logic [CW-1:0]          bit_cnt, cnt_nxt;

    logic bclk_rise, lr, sd, lr_chg, cap, full;
    logic err, emit, latch_left;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync  <= '0;
            lrck_sync  <= '0;
            sdata_sync <= '0;
            bclk_d     <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], bclk};
            lrck_sync  <= {lrck_sync[SYNC_STAGES-2:0], lrck};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata};
            bclk_d     <= bclk_sync[SYNC_STAGES-1];
        end
    end

    assign bclk_rise = bclk_sync[SYNC_STAGES-1] & ~bclk_d;
    assign lr        = lrck_sync[SYNC_STAGES-1];
    assign sd        = sdata_sync[SYNC_STAGES-1];
    assign lr_chg    = (lr != lr_prev);

    // Bits past CH_WIDTH in a slot are dropped; the counter saturates.
    assign cap       = bclk_rise && (state != IDLE) && (bit_cnt < FULL);
    assign shreg_nxt = cap ? {shreg[CH_WIDTH-2:0], sd} : shreg;
    assign cnt_nxt   = cap ? bit_cnt + CW'(1) : bit_cnt;
    assign full      = (cnt_nxt == FULL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        err        = 1'b0;
        emit       = 1'b0;
        latch_left = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
        end else if (bclk_rise) begin
            case (state)
                IDLE: if (lr_chg && !lr) state_nxt = LEFT;
                LEFT: begin
                    if (lr_chg && lr) begin
                        if (full) begin
                            latch_left = 1'b1;
                            state_nxt  = RIGHT;
                        end else begin
                            err       = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                RIGHT: begin
                    // The capture that fills the right word emits the frame, so
                    // this fires exactly once per right slot.
                    emit = cap && full;
                    if (lr_chg && !lr) begin
                        if (full) begin
                            state_nxt = LEFT;
                        end else begin
                            err       = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lr_prev   <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            left_hold <= '0;
            audio_out <= '0;
            valid_out <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid_out <= emit;
            frame_err <= err;
            if (bclk_rise) begin
                lr_prev <= lr;
                shreg   <= shreg_nxt;
                bit_cnt <= lr_chg ? '0 : cnt_nxt;
            end
            if (latch_left) left_hold <= shreg_nxt;
            if (emit)       audio_out <= DATA_WIDTH'({left_hold, shreg_nxt});
        end
    end

endmodule
